// File: rtl/synth_pkg.sv
// synth_pkg: frame geometry, write opcode and SPI port state encoding shared by the synth blocks
package synth_pkg;
  localparam int SPI_FRAME_BITS = 40;
  localparam logic [3:0] OPCODE_WRITE = 4'h1;
  localparam int REGISTER_NUMBER_WIDTH = 12;
  localparam int REGISTER_VALUE_WIDTH = 24;
  localparam int OPCODE_WIDTH = 4;
  localparam int STATUS_BITS = 8;
  localparam int BIT_COUNT_WIDTH = 6;
  typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CS} SpiPortState_t;
endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchroniser for one asynchronous input with a chosen idle level
module bit_synchronizer #(
  parameter int STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Async,
  output logic o_Sync
);
  logic [STAGES-1:0] r_sync;
  // shift the asynchronous input through the flop chain, presetting to the idle level
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) r_sync <= {STAGES{RESET_VALUE}};
    else r_sync <= {r_sync[STAGES-2:0], i_Async};
  assign o_Sync = r_sync[STAGES-1];
endmodule

// File: rtl/spi_register_port.sv
// spi_register_port: SPI mode-0 slave that turns 40-bit write frames into register write strobes
module spi_register_port
  import synth_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_SPI_SCLK,
  input  logic        i_SPI_CS_N,
  input  logic        i_SPI_MOSI,
  output logic        o_SPI_MISO,
  output logic [11:0] o_RegisterNumber,
  output logic [23:0] o_RegisterValue,
  output logic        o_RegisterWriteEnable
);
  logic w_sclk, w_cs_n, w_mosi;
  logic r_sclk_prev, r_cs_n_prev;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  logic w_last_bit, w_frame_write;
  logic [SPI_FRAME_BITS-1:0] w_frame;
  SpiPortState_t r_state;
  logic [SPI_FRAME_BITS-2:0] r_shift;
  logic [BIT_COUNT_WIDTH-1:0] r_bit_count;
  logic [STATUS_BITS-1:0] r_accept;
  logic [STATUS_BITS-1:0] r_miso;
  logic [REGISTER_NUMBER_WIDTH-1:0] r_number;
  logic [REGISTER_VALUE_WIDTH-1:0] r_value;
  logic r_write_enable;

  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sclk_sync (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SPI_SCLK), .o_Sync(w_sclk)
  );
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_cs_sync (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SPI_CS_N), .o_Sync(w_cs_n)
  );
  bit_synchronizer #(.STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_mosi_sync (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Async(i_SPI_MOSI), .o_Sync(w_mosi)
  );

  // one history flop per synchronised control line gives single-cycle edge pulses
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      r_sclk_prev <= 1'b0;
      r_cs_n_prev <= 1'b1;
    end else begin
      r_sclk_prev <= w_sclk;
      r_cs_n_prev <= w_cs_n;
    end

  assign w_sclk_rise = w_sclk & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk & r_sclk_prev;
  assign w_cs_fall = ~w_cs_n & r_cs_n_prev;
  assign w_cs_rise = w_cs_n & ~r_cs_n_prev;
  assign w_frame = {r_shift, w_mosi};
  assign w_last_bit = r_bit_count == BIT_COUNT_WIDTH'(SPI_FRAME_BITS - 1);
  assign w_frame_write = w_frame[SPI_FRAME_BITS-1 -: OPCODE_WIDTH] == OPCODE_WRITE;

  // frame FSM: capture bits, decode on the 40th rise, stream status out, abandon on CS release
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit_count <= '0;
      r_accept <= '0;
      r_miso <= '0;
      r_number <= '0;
      r_value <= '0;
      r_write_enable <= 1'b0;
    end else begin
      r_write_enable <= 1'b0;
      case (r_state)
        IDLE: if (w_cs_fall) begin
          r_state <= SHIFT;
          r_bit_count <= '0;
          r_miso <= r_accept;
        end
        SHIFT: if (w_sclk_rise) begin
          r_shift <= w_frame[SPI_FRAME_BITS-2:0];
          r_bit_count <= r_bit_count + BIT_COUNT_WIDTH'(1);
          if (w_last_bit) begin
            r_state <= WAIT_CS;
            if (w_frame_write) begin
              r_number <= w_frame[REGISTER_VALUE_WIDTH +: REGISTER_NUMBER_WIDTH];
              r_value <= w_frame[REGISTER_VALUE_WIDTH-1:0];
              r_write_enable <= 1'b1;
              r_accept <= r_accept + STATUS_BITS'(1);
            end
          end
        end
        default: ;
      endcase
      if (w_sclk_fall && r_state != IDLE) r_miso <= {r_miso[STATUS_BITS-2:0], 1'b0};
      if (w_cs_rise) r_state <= IDLE;
    end

  assign o_SPI_MISO = r_miso[STATUS_BITS-1] & ~w_cs_n;
  assign o_RegisterNumber = r_number;
  assign o_RegisterValue = r_value;
  assign o_RegisterWriteEnable = r_write_enable;
endmodule

// File: tb/tb_spi_register_port.sv
// tb_spi_register_port: directed frame table plus reset, gating and counter-wrap sequences
module tb_spi_register_port;
  logic i_Clock = 1'b0;
  logic i_Reset = 1'b1;
  logic i_SPI_SCLK = 1'b0;
  logic i_SPI_CS_N = 1'b1;
  logic i_SPI_MOSI = 1'b0;
  logic o_SPI_MISO;
  logic [11:0] o_RegisterNumber;
  logic [23:0] o_RegisterValue;
  logic o_RegisterWriteEnable;

  spi_register_port #(.SYNC_STAGES(2)) dut (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_SPI_SCLK(i_SPI_SCLK),
    .i_SPI_CS_N(i_SPI_CS_N),
    .i_SPI_MOSI(i_SPI_MOSI),
    .o_SPI_MISO(o_SPI_MISO),
    .o_RegisterNumber(o_RegisterNumber),
    .o_RegisterValue(o_RegisterValue),
    .o_RegisterWriteEnable(o_RegisterWriteEnable)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic [63:0] d;
    int n;
    bit cs_early;
    bit strobe;
    logic [11:0] num;
    logic [23:0] val;
    logic [7:0] st;
  } vec_t;

  vec_t vecs[11];
  int cyc = 0, strobes = 0, wide = 0, strobe_cyc = 0, rise_cyc = 0;
  int n_pass = 0, n_total = 0, s0;
  logic prev_we = 1'b0;
  logic [15:0] cap;
  logic [63:0] fr;

  always @(posedge i_Clock) cyc = cyc + 1;

  always @(negedge i_Clock) begin
    if (o_RegisterWriteEnable) begin
      strobes = strobes + 1;
      strobe_cyc = cyc;
      if (prev_we) wide = wide + 1;
    end
    prev_we = o_RegisterWriteEnable;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send(input logic [63:0] d, input int n, input bit cs_early, output logic [15:0] c);
    c = '0;
    i_SPI_CS_N = 1'b0;
    repeat (4) @(negedge i_Clock);
    for (int i = 0; i < n; i++) begin
      i_SPI_MOSI = d[n-1-i];
      repeat (4) @(negedge i_Clock);
      if (i < 16) c[15-i] = o_SPI_MISO;
      i_SPI_SCLK = 1'b1;
      if (i == 39) rise_cyc = cyc;
      if (cs_early && i == n - 1) i_SPI_CS_N = 1'b1;
      repeat (4) @(negedge i_Clock);
      i_SPI_SCLK = 1'b0;
    end
    i_SPI_CS_N = 1'b1;
    i_SPI_MOSI = 1'b0;
    repeat (4) @(negedge i_Clock);
  endtask

  initial begin
    vecs[0]  = '{64'h1005ABCDEF,  40, 1'b0, 1'b1, 12'h005, 24'hABCDEF, 8'h00};
    vecs[1]  = '{64'h2005123456,  40, 1'b0, 1'b0, 12'h005, 24'hABCDEF, 8'h01};
    vecs[2]  = '{64'h17777,       20, 1'b0, 1'b0, 12'h005, 24'hABCDEF, 8'h01};
    vecs[3]  = '{64'h1041000001,  40, 1'b0, 1'b1, 12'h041, 24'h000001, 8'h01};
    vecs[4]  = '{64'h1FFFFFFFFF,  40, 1'b0, 1'b1, 12'hFFF, 24'hFFFFFF, 8'h02};
    vecs[5]  = '{64'hF123456789,  40, 1'b0, 1'b0, 12'hFFF, 24'hFFFFFF, 8'h03};
    vecs[6]  = '{64'h1000000000,  40, 1'b0, 1'b1, 12'h000, 24'h000000, 8'h03};
    vecs[7]  = '{64'h1ABC123456F, 44, 1'b0, 1'b1, 12'hABC, 24'h123456, 8'h04};
    vecs[8]  = '{64'h0ABC000000,  40, 1'b0, 1'b0, 12'hABC, 24'h123456, 8'h05};
    vecs[9]  = '{64'h13C3C3C3C3,  40, 1'b1, 1'b1, 12'h3C3, 24'hC3C3C3, 8'h05};
    vecs[10] = '{64'h100A00000B,  40, 1'b0, 1'b1, 12'h00A, 24'h00000B, 8'h06};

    repeat (3) @(negedge i_Clock);
    chk("reset number", 64'(o_RegisterNumber), 64'h0);
    chk("reset value", 64'(o_RegisterValue), 64'h0);
    chk("reset strobe", 64'(o_RegisterWriteEnable), 64'h0);
    chk("reset miso", 64'(o_SPI_MISO), 64'h0);
    i_Reset = 1'b0;
    repeat (4) @(negedge i_Clock);

    for (int k = 0; k < 11; k++) begin
      s0 = strobes;
      send(vecs[k].d, vecs[k].n, vecs[k].cs_early, cap);
      chk($sformatf("v%0d strobes", k), 64'(strobes - s0), 64'(vecs[k].strobe));
      chk($sformatf("v%0d number", k), 64'(o_RegisterNumber), 64'(vecs[k].num));
      chk($sformatf("v%0d value", k), 64'(o_RegisterValue), 64'(vecs[k].val));
      chk($sformatf("v%0d status", k), 64'(cap), 64'({vecs[k].st, 8'h00}));
      if (vecs[k].strobe) chk($sformatf("v%0d latency", k), 64'(strobe_cyc - rise_cyc), 64'd3);
    end

    s0 = strobes;
    fr = 64'h1123ABCDEF;
    i_SPI_CS_N = 1'b0;
    repeat (4) @(negedge i_Clock);
    for (int i = 0; i < 25; i++) begin
      i_SPI_MOSI = fr[39-i];
      repeat (4) @(negedge i_Clock);
      i_SPI_SCLK = 1'b1;
      repeat (4) @(negedge i_Clock);
      i_SPI_SCLK = 1'b0;
    end
    i_Reset = 1'b1;
    repeat (2) @(negedge i_Clock);
    chk("midreset number", 64'(o_RegisterNumber), 64'h0);
    chk("midreset value", 64'(o_RegisterValue), 64'h0);
    chk("midreset strobe", 64'(o_RegisterWriteEnable), 64'h0);
    chk("midreset miso", 64'(o_SPI_MISO), 64'h0);
    i_SPI_CS_N = 1'b1;
    i_SPI_MOSI = 1'b0;
    repeat (3) @(negedge i_Clock);
    i_Reset = 1'b0;
    repeat (4) @(negedge i_Clock);
    chk("midreset no strobe", 64'(strobes - s0), 64'd0);
    send(64'h12AA55AA55, 40, 1'b0, cap);
    chk("after reset strobes", 64'(strobes - s0), 64'd1);
    chk("after reset number", 64'(o_RegisterNumber), 64'h2AA);
    chk("after reset value", 64'(o_RegisterValue), 64'h55AA55);
    chk("after reset status", 64'(cap), 64'h0000);

    s0 = strobes;
    for (int i = 0; i < 254; i++) begin
      if (i == 239) begin
        i_SPI_CS_N = 1'b0;
        repeat (6) @(negedge i_Clock);
        chk("miso cs low", 64'(o_SPI_MISO), 64'h1);
        i_SPI_CS_N = 1'b1;
        repeat (6) @(negedge i_Clock);
        chk("miso cs high", 64'(o_SPI_MISO), 64'h0);
      end
      send({24'h0, 4'h1, 12'(i), 24'(i * 3)}, 40, 1'b0, cap);
    end
    chk("wrap strobes", 64'(strobes - s0), 64'd254);
    chk("wrap number", 64'(o_RegisterNumber), 64'd253);
    chk("wrap value", 64'(o_RegisterValue), 64'd759);
    send(64'h1FFE000777, 40, 1'b0, cap);
    chk("status ff", 64'(cap), 64'hFF00);
    chk("ff number", 64'(o_RegisterNumber), 64'hFFE);
    send(64'h2000000000, 40, 1'b0, cap);
    chk("status wrapped", 64'(cap), 64'h0000);
    chk("wrap total strobes", 64'(strobes - s0), 64'd255);
    chk("wrap hold number", 64'(o_RegisterNumber), 64'hFFE);
    chk("strobe width", 64'(wide), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
